// File: rtl/pipeline_pkg.sv
// Shared types and constants for the front end of the 5-stage ARM pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request to imem outstanding for PCF
        HOLD  = 2'd1,   // fetched word parked in the hold buffer, decode stalled
        DRAIN = 2'd2    // redirected while a request was in flight; wait out its ack
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;  // MOV r0,r0
    localparam logic [31:0] PC_STEP           = 32'd4;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } fd_t;

endpackage

// File: rtl/flop_fd.sv
// IF/ID pipeline register: enable, synchronous clear to a bubble, async active-low reset.
// Latency: 1 cycle from d to q.
// Backpressure: en=0 holds q; clr wins over en so a flush lands even while stalled.
//
// Ports: clk, reset (async, active-low), en (load), clr (sync squash), d/q (fd_t).
module flop_fd
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  fd_t  d,
    output fd_t  q
);

    localparam fd_t BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, valid: 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= BUBBLE;
        end else if (clr) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PCF, a req/ack imem handshake, a one-entry hold buffer and IF/ID.
// Latency: 1 cycle from imem_ack to InstrD; one instruction per cycle with back-to-back acks.
// Backpressure: StallD parks an acked word in the hold buffer and drops imem_req until released.
//
// Ports: clk/reset (async, active-low); hazard StallD/FlushD; writeback redirect PCSrcW/ResultW;
//        imem_req/imem_addr/imem_ack/imem_rdata; PCPlus4F to datapath; InstrD/PCD/ValidD to
//        decode; FetchBusy = request outstanding with no ack this cycle.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic        ValidD,
    output logic        FetchBusy
);

    fetch_state_t state, stateNext;
    logic [31:0]  pcF, pcFNext;
    logic         bufVld, bufVldNext;
    logic [31:0]  bufDat, bufDatNext;
    logic [31:0]  redirPc, redirPcNext;

    logic         available;
    logic         advance;
    logic [31:0]  fetchInstr;
    fd_t          fdIn, fdOut;

    // An ack only counts as an instruction in FETCH; in DRAIN it belongs to a killed request.
    assign available  = ((state == FETCH) && imem_ack) || bufVld;
    assign advance    = available && !StallD && !PCSrcW;
    assign fetchInstr = bufVld ? bufDat : imem_rdata;

    // Gating with reset keeps the request low for the whole time reset is held, and lets the
    // first request go out as soon as reset is released.
    assign imem_req  = reset && (state != HOLD);
    assign imem_addr = {pcF[31:2], 2'b00};
    assign PCPlus4F  = pcF + PC_STEP;
    assign FetchBusy = imem_req && !imem_ack;

    always_comb begin
        stateNext   = state;
        pcFNext     = pcF;
        bufVldNext  = bufVld;
        bufDatNext  = bufDat;
        redirPcNext = redirPc;
        unique case (state)
            FETCH: begin
                if (PCSrcW && imem_ack) begin
                    pcFNext = ResultW;
                end else if (PCSrcW) begin
                    // Address must stay stable until the in-flight request is acked.
                    redirPcNext = ResultW;
                    stateNext   = DRAIN;
                end else if (imem_ack && StallD) begin
                    bufVldNext = 1'b1;
                    bufDatNext = imem_rdata;
                    stateNext  = HOLD;
                end else if (imem_ack) begin
                    pcFNext = pcF + PC_STEP;
                end
            end
            HOLD: begin
                if (PCSrcW) begin
                    bufVldNext = 1'b0;
                    pcFNext    = ResultW;
                    stateNext  = FETCH;
                end else if (!StallD) begin
                    bufVldNext = 1'b0;
                    pcFNext    = pcF + PC_STEP;
                    stateNext  = FETCH;
                end
            end
            DRAIN: begin
                if (PCSrcW) begin
                    redirPcNext = ResultW;
                end
                if (imem_ack) begin
                    pcFNext   = PCSrcW ? ResultW : redirPc;
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pcF     <= RESET_PC;
            bufVld  <= 1'b0;
            bufDat  <= 32'd0;
            redirPc <= 32'd0;
        end else begin
            state   <= stateNext;
            pcF     <= pcFNext;
            bufVld  <= bufVldNext;
            bufDat  <= bufDatNext;
            redirPc <= redirPcNext;
        end
    end

    // A non-advancing, non-stalled cycle loads a bubble.
    always_comb begin
        fdIn = '{instr: NOP_INSTR, pc: 32'd0, valid: 1'b0};
        if (advance) begin
            fdIn = '{instr: fetchInstr, pc: pcF, valid: 1'b1};
        end
    end

    flop_fd #(
        .NOP_INSTR (NOP_INSTR)
    ) u_flop_fd (
        .clk   (clk),
        .reset (reset),
        .en    (!StallD),
        .clr   (FlushD || PCSrcW),
        .d     (fdIn),
        .q     (fdOut)
    );

    assign InstrD = fdOut.instr;
    assign PCD    = fdOut.pc;
    assign ValidD = fdOut.valid;

endmodule
